imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEM_LOG2, default 17, word-index width of the instruction memory; equals InstMemNumLog2.
REQ-002 Parameter MAX_WAIT, default 4, maximum consecutive fetch grants while loader waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  fetch stage read request.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_flush  input  1  branch/exception flush; discards in-flight fetch response.
REQ-008 if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 if_rvalid  output  1  fetch read data valid (registered).
REQ-010 if_rdata  output  32  fetch instruction word.
REQ-011 ld_req / ld_we  input  1 / 1  loader request / write qualifier.
REQ-012 ld_addr / ld_wdata  input  32 / 32  loader byte address / write data.
REQ-013 ld_mode  input  1  program-load mode; blocks all fetch grants.
REQ-014 ld_gnt  output  1  loader request accepted this cycle (combinational).
REQ-015 ld_rvalid  output  1  loader read data or write acknowledge (registered).
REQ-016 ld_rdata  output  32  loader read data; 0 on write acknowledge.
REQ-017 err  output  1  registered; out-of-range access flagged with the response.
REQ-018 mem_ce / mem_we  output  1 / 1  memory chip enable / write enable.
REQ-019 mem_addr  output  MEM_LOG2  word index; mem_wdata  output  32; mem_rdata  input  32, valid one cycle after mem_ce.

Function
REQ-020 At most one grant per cycle; grant and memory access issue in the same cycle as the request.
REQ-021 Only one requester active: that requester SHALL be granted (fetch never granted while ld_mode=1).
REQ-022 Both active: loader granted if ld_mode=1 or starve count equals MAX_WAIT; otherwise fetch granted.
REQ-023 Starve count: +1 each cycle ld_req=1 and fetch granted, saturates at MAX_WAIT; cleared on loader grant or ld_req=0.
REQ-024 Granted access: mem_addr = addr[MEM_LOG2+1:2]; addr[1:0] ignored; mem_we = ld_we for loader, 0 for fetch.
REQ-025 Out-of-range (addr[31:MEM_LOG2+2] nonzero): grant still asserted, mem_ce=0, response next cycle with rdata 0 and err=1.
REQ-026 Owner register, states NONE, IF, LD: set to granted requester each cycle, NONE when no grant.
REQ-027 Response: cycle after grant, rvalid=1 to owner only, rdata = mem_rdata (read) or 0 (write/out-of-range); 1-cycle latency, back-to-back accepted.
REQ-028 if_flush=1 in the grant cycle or the response cycle: if_rvalid SHALL be 0 for that fetch; owner cleared to NONE.
REQ-029 if_flush does not affect loader grants, responses or starve count.
REQ-030 mem_ce=0 and mem_we=0 whenever no grant; mem_wdata = ld_wdata always.
REQ-031 err and rvalid pulse one cycle only; no response without a prior grant.

Reset
REQ-032 While rst=1: owner NONE, starve count 0, if_rvalid, ld_rvalid, err 0, if_rdata, ld_rdata 0, no grants, mem_ce 0, mem_we 0.
REQ-033 Reset mid-access: in-flight response discarded, never delivered after reset release.

Structure
REQ-034 Shared defines file holds ChipEnable/ChipDisable, InstAddrBus, InstBus, InstMemNumLog2, new ImemMaxWait; owner state encodings local.
REQ-035 No sub-module; starve counter and owner register inline.

Verification
REQ-036 if_req=1, if_addr=0x00000008, mem word 2=0x34011100 -> if_gnt same cycle, mem_addr=2, next cycle if_rvalid=1, if_rdata=0x34011100.
REQ-037 if_req and ld_req held 1, ld_mode=0 -> 4 fetch grants, then ld_gnt on cycle 5, count cleared, fetch resumes.
REQ-038 ld_mode=1, ld_we=1, ld_addr=0x10, ld_wdata=0xDEADBEEF, if_req=1 -> if_gnt=0, mem_we=1, mem_addr=4, next cycle ld_rvalid=1, ld_rdata=0.
REQ-039 Fetch granted, if_flush=1 in response cycle -> if_rvalid=0; following fetch to 0x4 returns normally.
REQ-040 if_addr=0x00080000 (MEM_LOG2=17) -> if_gnt=1, mem_ce=0, next cycle if_rvalid=1, err=1, if_rdata=0.
REQ-041 rst asserted in cycle after grant -> no rvalid during or after reset; all outputs at reset values.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared instruction-memory definitions for the fetch/loader arbiter.
// Bus widths, memory geometry, chip-enable levels and address helpers.
package imem_arbiter_pkg;

    localparam logic ChipEnable     = 1'b1;
    localparam logic ChipDisable    = 1'b0;

    localparam int   InstAddrBus    = 32;
    localparam int   InstBus        = 32;
    localparam int   InstMemNumLog2 = 17;
    localparam int   ImemMaxWait    = 4;

    // True when the byte address falls beyond the word-indexed memory.
    function automatic logic addr_out_of_range(
        input logic [InstAddrBus-1:0] addr,
        input int unsigned            mem_log2
    );
        logic [InstAddrBus-1:0] hi;
        hi = addr >> (mem_log2 + 2);
        return hi != '0;
    endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between fetch and program loader.
// One grant per cycle, 1-cycle response, loader starvation bounded.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int MEM_LOG2 = InstMemNumLog2,
    parameter int MAX_WAIT = ImemMaxWait
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    input  logic                   if_flush,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [InstBus-1:0]     if_rdata,

    input  logic                   ld_req,
    input  logic                   ld_we,
    input  logic [InstAddrBus-1:0] ld_addr,
    input  logic [InstBus-1:0]     ld_wdata,
    input  logic                   ld_mode,
    output logic                   ld_gnt,
    output logic                   ld_rvalid,
    output logic [InstBus-1:0]     ld_rdata,

    output logic                   err,

    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [MEM_LOG2-1:0]    mem_addr,
    output logic [InstBus-1:0]     mem_wdata,
    input  logic [InstBus-1:0]     mem_rdata
);

    localparam int CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    owner_e                 r_owner;
    logic                   r_oor;
    logic                   r_wr;
    logic [CntW-1:0]        r_starve;

    logic                   w_if_act;
    logic                   w_ld_act;
    logic                   w_starved;
    logic                   w_if_gnt;
    logic                   w_ld_gnt;
    logic                   w_any_gnt;
    logic [InstAddrBus-1:0] w_addr;
    logic                   w_oor;
    logic                   w_if_rvalid;
    logic                   w_ld_rvalid;

    // Request qualification and grant selection; nothing is granted in reset.
    always_comb begin
        w_if_act  = if_req & ~ld_mode & ~rst;
        w_ld_act  = ld_req & ~rst;
        w_starved = (r_starve == CntW'(MAX_WAIT));
        w_ld_gnt  = w_ld_act & (~w_if_act | ld_mode | w_starved);
        w_if_gnt  = w_if_act & ~w_ld_gnt;
        w_any_gnt = w_if_gnt | w_ld_gnt;
    end

    // Address mux and range check for the granted requester.
    always_comb begin
        w_addr = w_ld_gnt ? ld_addr : if_addr;
        w_oor  = addr_out_of_range(w_addr, MEM_LOG2);
    end

    // Memory port drive; out-of-range grants never touch the array.
    always_comb begin
        mem_ce    = (w_any_gnt & ~w_oor) ? ChipEnable : ChipDisable;
        mem_we    = w_ld_gnt & ld_we & ~w_oor;
        mem_addr  = w_addr[MEM_LOG2+1:2];
        mem_wdata = ld_wdata;
    end

    assign if_gnt = w_if_gnt;
    assign ld_gnt = w_ld_gnt;

    // Loader starvation counter, saturating at MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!ld_req || w_ld_gnt) begin
            r_starve <= '0;
        end else if (w_if_gnt && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Owner of next cycle's response; a flushed fetch owns nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_oor   <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_oor <= w_any_gnt & w_oor;
            r_wr  <= w_ld_gnt & ld_we;
            if (w_ld_gnt) begin
                r_owner <= OWN_LD;
            end else if (w_if_gnt && !if_flush) begin
                r_owner <= OWN_IF;
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

    // Response steering; a flush in the response cycle still kills the fetch.
    always_comb begin
        w_if_rvalid = (r_owner == OWN_IF) & ~if_flush;
        w_ld_rvalid = (r_owner == OWN_LD);
        if_rvalid   = w_if_rvalid;
        ld_rvalid   = w_ld_rvalid;
        err         = r_oor & (w_if_rvalid | w_ld_rvalid);
        if_rdata    = (w_if_rvalid & ~r_oor) ? mem_rdata : '0;
        ld_rdata    = (w_ld_rvalid & ~r_oor & ~r_wr) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: behavioural model plus
// directed vectors with literal expectations.
module tb_imem_arbiter;

    localparam int ML = 17;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 0, if_flush = 0, ld_req = 0, ld_we = 0, ld_mode = 0;
    logic [31:0] if_addr = 0, ld_addr = 0, ld_wdata = 0;
    logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, err, mem_ce, mem_we;
    logic [31:0] if_rdata, ld_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic [ML-1:0] mem_addr;

    imem_arbiter #(.MEM_LOG2(ML), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_mode(ld_mode), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .err(err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 2) return 32'h3401_1100;
        return 32'h1000_0000 + i * 32'h0001_0003;
    endfunction

    // Memory array seen by the DUT
    logic [31:0] mem [int unsigned];
    function automatic logic [31:0] mem_rd(input int unsigned i);
        return mem.exists(i) ? mem[i] : init_word(i);
    endfunction

    always @(posedge clk) begin
        if (mem_ce === 1'b1 && mem_we === 1'b0) begin
            mem_rdata <= mem_rd(32'(mem_addr));
        end else begin
            if (mem_ce === 1'b1 && mem_we === 1'b1)
                mem[32'(mem_addr)] = mem_wdata;
            mem_rdata <= 32'hBAD0_BAD0;
        end
    end

    // Model: expected memory image, starve count, pending response
    logic [31:0] em [int unsigned];
    function automatic logic [31:0] em_rd(input int unsigned i);
        return em.exists(i) ? em[i] : init_word(i);
    endfunction

    int          cnt = 0;
    bit          p_if = 0, p_ld = 0, p_oor = 0;
    logic [31:0] p_data = 0;

    // 0 none, 1 fetch, 2 loader
    function automatic int pick();
        bit fw;
        fw = if_req && !ld_mode;
        if (rst) return 0;
        if (ld_req && (!fw || cnt >= MW)) return 2;
        if (fw) return 1;
        return 0;
    endfunction

    function automatic bit beyond(input logic [31:0] a);
        return longint'(a) >= (longint'(1) << (ML + 2));
    endfunction

    always @(posedge clk) begin
        int g;
        logic [31:0] a;
        bit oor;
        if (rst) begin
            cnt = 0; p_if = 0; p_ld = 0; p_oor = 0; p_data = 0;
        end else begin
            g = pick();
            a = (g == 2) ? ld_addr : if_addr;
            oor = beyond(a);
            p_if = (g == 1) && !if_flush;
            p_ld = (g == 2);
            p_oor = (g != 0) && oor;
            p_data = 0;
            if (g != 0 && !oor) begin
                if (g == 2 && ld_we) em[a / 4] = ld_wdata;
                else p_data = em_rd(a / 4);
            end
            if (g == 2 || !ld_req) cnt = 0;
            else if (g == 1 && cnt < MW) cnt++;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [31:0] a;
        bit oor, eiv, elv;
        g = pick();
        a = (g == 2) ? ld_addr : if_addr;
        oor = beyond(a);
        chk("if_gnt", 32'(if_gnt), 32'(g == 1));
        chk("ld_gnt", 32'(ld_gnt), 32'(g == 2));
        chk("mem_ce", 32'(mem_ce), 32'(g != 0 && !oor));
        chk("mem_we", 32'(mem_we), 32'(g == 2 && !oor && ld_we));
        if (g != 0 && !oor) chk("mem_addr", 32'(mem_addr), a / 4);
        chk("mem_wdata", mem_wdata, ld_wdata);
        eiv = !rst && p_if && !if_flush;
        elv = !rst && p_ld;
        chk("if_rvalid", 32'(if_rvalid), 32'(eiv));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(elv));
        chk("err", 32'(err), 32'(p_oor && (eiv || elv)));
        chk("if_rdata", if_rdata, eiv ? p_data : 32'h0);
        chk("ld_rdata", ld_rdata, elv ? p_data : 32'h0);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; ld_req = 0; ld_we = 0; ld_mode = 0; if_flush = 0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("L_rst_if_rvalid", 32'(if_rvalid), 0);
        chk("L_rst_ld_rvalid", 32'(ld_rvalid), 0);
        chk("L_rst_mem_ce", 32'(mem_ce), 0);
        nxt(); rst = 0;

        // basic fetch of word 2
        nxt(); if_req = 1; if_addr = 32'h8;
        @(negedge clk);
        chk("L_fetch_gnt", 32'(if_gnt), 1);
        chk("L_fetch_addr", 32'(mem_addr), 2);
        nxt(); idle();
        @(negedge clk);
        chk("L_fetch_rvalid", 32'(if_rvalid), 1);
        chk("L_fetch_rdata", if_rdata, 32'h3401_1100);

        // loader starvation bound
        nxt(); if_req = 1; if_addr = 32'h10; ld_req = 1; ld_addr = 32'h20;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) chk("L_starve_ld_gnt", 32'(ld_gnt), 1);
            else chk("L_starve_if_gnt", 32'(if_gnt), 1);
            if (c == 6) chk("L_starve_ld_rdata", ld_rdata, 32'h1008_0018);
        end
        nxt(); idle();

        // program-load write blocks fetch
        nxt(); ld_mode = 1; ld_req = 1; ld_we = 1; ld_addr = 32'h10;
        ld_wdata = 32'hDEAD_BEEF; if_req = 1; if_addr = 32'h0;
        @(negedge clk);
        chk("L_load_if_gnt", 32'(if_gnt), 0);
        chk("L_load_mem_we", 32'(mem_we), 1);
        chk("L_load_mem_addr", 32'(mem_addr), 4);
        nxt(); idle();
        @(negedge clk);
        chk("L_load_ack", 32'(ld_rvalid), 1);
        chk("L_load_ack_data", ld_rdata, 0);
        nxt(); if_req = 1; if_addr = 32'h10;
        nxt(); idle();
        @(negedge clk);
        chk("L_readback", if_rdata, 32'hDEAD_BEEF);

        // flush in response cycle, then normal fetch
        nxt(); if_req = 1; if_addr = 32'h0;
        nxt(); idle(); if_flush = 1;
        @(negedge clk);
        chk("L_flush_resp", 32'(if_rvalid), 0);
        nxt(); if_flush = 0; if_req = 1; if_addr = 32'h4;
        nxt(); idle();
        @(negedge clk);
        chk("L_after_flush_v", 32'(if_rvalid), 1);
        chk("L_after_flush_d", if_rdata, 32'h1001_0003);

        // flush in grant cycle
        nxt(); if_req = 1; if_addr = 32'h4; if_flush = 1;
        nxt(); idle();
        @(negedge clk);
        chk("L_flush_gnt", 32'(if_rvalid), 0);

        // out-of-range fetch
        nxt(); if_req = 1; if_addr = 32'h0008_0000;
        @(negedge clk);
        chk("L_oor_gnt", 32'(if_gnt), 1);
        chk("L_oor_ce", 32'(mem_ce), 0);
        nxt(); idle();
        @(negedge clk);
        chk("L_oor_rvalid", 32'(if_rvalid), 1);
        chk("L_oor_err", 32'(err), 1);
        chk("L_oor_rdata", if_rdata, 0);

        // out-of-range loader write
        nxt(); ld_req = 1; ld_we = 1; ld_addr = 32'h0010_0000;
        @(negedge clk);
        chk("L_ldoor_we", 32'(mem_we), 0);
        nxt(); idle();
        @(negedge clk);
        chk("L_ldoor_err", 32'(err), 1);

        // reset right after a grant
        nxt(); if_req = 1; if_addr = 32'h8;
        nxt(); idle(); rst = 1;
        @(negedge clk);
        chk("L_rst_mid_rvalid", 32'(if_rvalid), 0);
        chk("L_rst_mid_rdata", if_rdata, 0);
        nxt(); if_req = 1;
        @(negedge clk);
        chk("L_rst_no_gnt", 32'(if_gnt), 0);
        nxt(); idle(); rst = 0;
        @(negedge clk);
        chk("L_rst_after", 32'(if_rvalid), 0);

        // mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            nxt();
            if_req   = 1'($urandom_range(0, 1));
            ld_req   = 1'($urandom_range(0, 1));
            ld_we    = 1'($urandom_range(0, 1));
            ld_mode  = ($urandom_range(0, 7) == 0);
            if_flush = ($urandom_range(0, 5) == 0);
            if_addr  = ($urandom_range(0, 9) == 0) ? 32'h0100_0000
                                                   : 32'($urandom_range(0, 63)) << 2;
            ld_addr  = 32'($urandom_range(0, 63)) << 2;
            ld_wdata = $urandom;
        end
        nxt(); idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
